// File: rtl/shade_output_collector.sv
// shade_output_collector: round-robin collects shaded fragments from the ray cores,
// computes framebuffer byte addresses and streams pixel writes to the memory controller.
module shade_output_collector #(
    parameter int RAY_CORE_SIZE = 4,
    parameter int FB_WIDTH      = 320,
    parameter int FB_HEIGHT     = 240,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [RAY_CORE_SIZE-1:0]       shade_valid,
    output logic [RAY_CORE_SIZE-1:0]       shade_ready,
    input  logic [RAY_CORE_SIZE-1:0][9:0]  shade_x,
    input  logic [RAY_CORE_SIZE-1:0][9:0]  shade_y,
    input  logic [RAY_CORE_SIZE-1:0][23:0] shade_color,
    input  logic [31:0]                    fb_base,
    input  logic                           frame_start,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [31:0]                    mem_req_addr,
    output logic [31:0]                    mem_req_data,
    output logic [19:0]                    pixel_count,
    output logic                           frame_done,
    output logic                           oob_error
);
    localparam int PW = RAY_CORE_SIZE > 1 ? $clog2(RAY_CORE_SIZE) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [19:0] TOTAL = 20'(FB_WIDTH * FB_HEIGHT);

    logic [PW-1:0] rr_ptr, grant_idx, cand;
    logic          grant_any, accept, in_range, pop;
    logic [9:0]    sel_x, sel_y;
    logic [31:0]   sel_addr;
    logic          stage_valid;
    logic [31:0]   stage_addr, stage_data;
    logic [AW:0]   fifo_count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];

    // Scan downwards so the core closest to rr_ptr overrides later candidates.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        cand = rr_ptr;
        for (int k = RAY_CORE_SIZE - 1; k >= 0; k--) begin
            cand = PW'((int'(rr_ptr) + k) % RAY_CORE_SIZE);
            if (shade_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Credit counts the stage slot so the FIFO can never overflow.
    assign accept      = resetn && grant_any && (int'(fifo_count) + int'(stage_valid) < FIFO_DEPTH);
    assign shade_ready = accept ? RAY_CORE_SIZE'(1) << grant_idx : '0;
    assign sel_x       = shade_x[grant_idx];
    assign sel_y       = shade_y[grant_idx];
    assign in_range    = 32'(sel_x) < FB_WIDTH && 32'(sel_y) < FB_HEIGHT;
    assign sel_addr    = fb_base + ((32'(sel_y) * 32'(FB_WIDTH) + 32'(sel_x)) << 2);

    assign mem_req_valid = fifo_count != '0;
    assign pop           = mem_req_valid && mem_req_ready;
    assign mem_req_addr  = fifo_addr[rd_ptr];
    assign mem_req_data  = fifo_data[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr      <= '0;
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            oob_error   <= 1'b0;
        end else begin
            stage_valid <= accept && in_range;
            if (accept) begin
                rr_ptr     <= PW'((int'(grant_idx) + 1) % RAY_CORE_SIZE);
                stage_addr <= sel_addr;
                stage_data <= {8'h00, shade_color[grant_idx]};
            end
            wr_ptr     <= wr_ptr + AW'(stage_valid);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + (AW+1)'(stage_valid) - (AW+1)'(pop);
            if (frame_start) begin
                pixel_count <= {19'd0, pop};
                frame_done  <= 1'b0;
                oob_error   <= 1'b0;
            end else begin
                if (pop && pixel_count != TOTAL) pixel_count <= pixel_count + 20'd1;
                if (pixel_count == TOTAL) frame_done <= 1'b1;
                if (accept && !in_range) oob_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (stage_valid) begin
            fifo_addr[wr_ptr] <= stage_addr;
            fifo_data[wr_ptr] <= stage_data;
        end
    end
endmodule

// File: tb/tb_shade_output_collector.sv
// tb_shade_output_collector: directed vectors for shade_output_collector, plus a small
// 8x4 framebuffer instance for frame completion and frame_start corner cases.
module tb_shade_output_collector;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [3:0] shade_valid = '0, shade_ready;
    logic [3:0][9:0] shade_x = '0, shade_y = '0;
    logic [3:0][23:0] shade_color = '0;
    logic [31:0] fb_base = '0, mem_req_addr, mem_req_data;
    logic frame_start = 1'b0, mem_req_valid, mem_req_ready = 1'b1, frame_done, oob_error;
    logic [19:0] pixel_count;

    logic [3:0] s2_valid = '0, s2_ready;
    logic [3:0][9:0] s2_x = '0, s2_y = '0;
    logic [3:0][23:0] s2_col = '0;
    logic [31:0] fb_base2 = '0, ma2, md2;
    logic fs2 = 1'b0, mv2, mr2 = 1'b1, fd2, oe2;
    logic [19:0] pc2;

    always #5 clk = ~clk;

    shade_output_collector dut (
        .clk(clk), .resetn(resetn), .shade_valid(shade_valid), .shade_ready(shade_ready),
        .shade_x(shade_x), .shade_y(shade_y), .shade_color(shade_color), .fb_base(fb_base),
        .frame_start(frame_start), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .pixel_count(pixel_count),
        .frame_done(frame_done), .oob_error(oob_error)
    );

    shade_output_collector #(.FB_WIDTH(8), .FB_HEIGHT(4)) dut2 (
        .clk(clk), .resetn(resetn), .shade_valid(s2_valid), .shade_ready(s2_ready),
        .shade_x(s2_x), .shade_y(s2_y), .shade_color(s2_col), .fb_base(fb_base2),
        .frame_start(fs2), .mem_req_valid(mv2), .mem_req_ready(mr2),
        .mem_req_addr(ma2), .mem_req_data(md2), .pixel_count(pc2),
        .frame_done(fd2), .oob_error(oe2)
    );

    typedef struct packed {
        int          core;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] col;
        logic [31:0] base;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tv [6];
    int checks = 0, errors = 0, exp_cnt = 0, nxt = 0;
    int gq [$];
    logic [31:0] wa [$], wd [$];

    // Grants and memory handshakes are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (shade_valid[i] && shade_ready[i]) gq.push_back(i);
        if (mem_req_valid && mem_req_ready) begin
            wa.push_back(mem_req_addr);
            wd.push_back(mem_req_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int c);
        return 32'h0001_0000 + 32'((c * 320 + c * 10 + 1) * 4);
    endfunction

    function automatic logic [31:0] data_of(input int c);
        return {8'h00, 24'hC00000 | 24'(c)};
    endfunction

    task automatic set_cores();
        fb_base = 32'h0001_0000;
        for (int c = 0; c < 4; c++) begin
            shade_x[c] = 10'(c * 10 + 1);
            shade_y[c] = 10'(c);
            shade_color[c] = 24'hC00000 | 24'(c);
        end
    endtask

    task automatic clear_q();
        gq.delete();
        wa.delete();
        wd.delete();
    endtask

    task automatic run_vec(input vec_t v);
        shade_x[v.core] = v.x;
        shade_y[v.core] = v.y;
        shade_color[v.core] = v.col;
        fb_base = v.base;
        shade_valid = 4'(1 << v.core);
        #1 chk("vec_ready", 32'(shade_ready), 32'(1 << v.core));
        @(posedge clk); #1;
        shade_valid = '0;
        chk("vec_stage_no_req", 32'(mem_req_valid), 0);
        @(posedge clk); #1;
        chk("vec_req_valid", 32'(mem_req_valid), 1);
        chk("vec_addr", mem_req_addr, v.exp_addr);
        chk("vec_data", mem_req_data, {8'h00, v.col});
        @(posedge clk); #1;
        exp_cnt++;
        nxt = (v.core + 1) % 4;
        chk("vec_count", 32'(pixel_count), 32'(exp_cnt));
    endtask

    task automatic wait_writes(input int n);
        for (int c = 0; c < 100 && wa.size() < n; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk("write_count", 32'(wa.size()), 32'(n));
    endtask

    task automatic check_order(input int n);
        int g;
        logic [31:0] a, d;
        for (int i = 0; i < n; i++) begin
            g = i < gq.size() ? gq[i] : -1;
            a = i < wa.size() ? wa[i] : 32'hDEAD_DEAD;
            d = i < wd.size() ? wd[i] : 32'hDEAD_DEAD;
            chk("grant_order", 32'(g), 32'((nxt + i) % 4));
            chk("write_addr", a, addr_of((nxt + i) % 4));
            chk("write_data", d, data_of((nxt + i) % 4));
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_cnt = 0;
        chk("fs_count", 32'(pixel_count), 0);
        chk("fs_done", 32'(frame_done), 0);
        chk("fs_oob", 32'(oob_error), 0);
    endtask

    task automatic send_oob(input logic [9:0] x, input logic [9:0] y);
        clear_q();
        shade_x[1] = x;
        shade_y[1] = y;
        shade_valid = 4'b0010;
        #1 chk("oob_ready", 32'(shade_ready), 32'h2);
        @(posedge clk); #1;
        shade_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("oob_no_req", 32'(mem_req_valid), 0);
        chk("oob_no_write", 32'(wa.size()), 0);
        chk("oob_flag", 32'(oob_error), 1);
        chk("oob_count", 32'(pixel_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{0, 10'd3,   10'd2,   24'h112233, 32'h0000_1000, 32'h0000_1A0C};
        tv[1] = '{1, 10'd0,   10'd0,   24'hABCDEF, 32'h0000_0000, 32'h0000_0000};
        tv[2] = '{2, 10'd319, 10'd239, 24'hFFFFFF, 32'h2000_0000, 32'h2004_AFFC};
        tv[3] = '{3, 10'd100, 10'd50,  24'h000001, 32'h8000_0004, 32'h8000_FB94};
        tv[4] = '{0, 10'd319, 10'd239, 24'h5A5A5A, 32'hFFFF_FFFC, 32'h0004_AFF8};
        tv[5] = '{2, 10'd1,   10'd1,   24'h00FF00, 32'h0000_0004, 32'h0000_0508};

        shade_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(shade_ready), 0);
        chk("rst_req_valid", 32'(mem_req_valid), 0);
        chk("rst_count", 32'(pixel_count), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_oob", 32'(oob_error), 0);
        shade_valid = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(tv[i]);

        // Round robin with every core asking continuously.
        clear_q();
        set_cores();
        shade_valid = 4'hF;
        for (int c = 0; c < 50 && gq.size() < 8; c++) @(posedge clk);
        #1 shade_valid = '0;
        wait_writes(8);
        check_order(8);
        exp_cnt += 8;
        chk("rr_count", 32'(pixel_count), 32'(exp_cnt));

        // Backpressure fills the queue exactly, then drains in grant order.
        clear_q();
        mem_req_ready = 1'b0;
        shade_valid = 4'hF;
        repeat (20) @(posedge clk);
        #1;
        chk("bp_grants", 32'(gq.size()), 8);
        chk("bp_ready_low", 32'(shade_ready), 0);
        chk("bp_req_valid", 32'(mem_req_valid), 1);
        chk("bp_head_addr", mem_req_addr, addr_of(nxt));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_addr_hold", mem_req_addr, addr_of(nxt));
        chk("bp_data_hold", mem_req_data, data_of(nxt));
        chk("bp_count_hold", 32'(pixel_count), 32'(exp_cnt));
        shade_valid = '0;
        mem_req_ready = 1'b1;
        wait_writes(8);
        check_order(8);
        exp_cnt += 8;
        chk("bp_count", 32'(pixel_count), 32'(exp_cnt));

        send_oob(10'd320, 10'd0);
        pulse_frame_start();
        send_oob(10'd0, 10'd240);
        pulse_frame_start();

        // Small-frame instance: 32 pixels complete the frame.
        for (int i = 0; i < 32; i++) begin
            s2_x[0] = 10'(i % 8);
            s2_y[0] = 10'(i / 8);
            s2_col[0] = 24'(i);
            s2_valid = 4'b0001;
            @(posedge clk); #1;
        end
        s2_valid = '0;
        for (int c = 0; c < 20 && pc2 != 20'd32; c++) begin
            @(posedge clk); #1;
        end
        chk("fd_count_total", 32'(pc2), 32);
        chk("fd_not_yet", 32'(fd2), 0);
        @(posedge clk); #1;
        chk("fd_set", 32'(fd2), 1);
        s2_x[0] = '0;
        s2_y[0] = '0;
        s2_valid = 4'b0001;
        repeat (2) @(posedge clk);
        #1 s2_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("fd_saturate", 32'(pc2), 32);
        chk("fd_sticky", 32'(fd2), 1);
        s2_valid = 4'b0001;
        @(posedge clk); #1;
        s2_valid = '0;
        @(posedge clk); #1;
        chk("fs_hs_req", 32'(mv2), 1);
        fs2 = 1'b1;
        @(posedge clk); #1;
        fs2 = 1'b0;
        chk("fs_hs_count", 32'(pc2), 1);
        chk("fs_hs_done", 32'(fd2), 0);
        @(posedge clk); #1;
        chk("fs_hs_done_stays", 32'(fd2), 0);

        // Reset with five pixels queued.
        clear_q();
        set_cores();
        mem_req_ready = 1'b0;
        shade_valid = 4'hF;
        for (int c = 0; c < 50 && gq.size() < 5; c++) @(posedge clk);
        #1 shade_valid = '0;
        repeat (3) @(posedge clk);
        #1 chk("mid_req_valid", 32'(mem_req_valid), 1);
        #2 resetn = 1'b0;
        shade_valid = 4'hF;
        #1;
        chk("mid_rst_req", 32'(mem_req_valid), 0);
        chk("mid_rst_ready", 32'(shade_ready), 0);
        chk("mid_rst_count", 32'(pixel_count), 0);
        shade_valid = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        mem_req_ready = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;
        chk("post_rst_req", 32'(mem_req_valid), 0);
        run_vec(tv[0]);
        run_vec(tv[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
